instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, program-memory address width; depth is 2**ADDR_W words.
REQ-002 Parameter IR_W, default 9, instruction width; fields are opcode[8:6], rx[5:3], ry[2:0].
REQ-003 clock_tb  input  1  clock; all state updates on the rising edge.
REQ-004 resetn_tb  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse that begins execution at address 0.
REQ-006 prog_we  input  1  program-memory write enable.
REQ-007 prog_addr  input  ADDR_W  program-memory write address.
REQ-008 prog_data  input  IR_W  program-memory write data.
REQ-009 done  input  1  instruction-complete strobe from the control unit, sampled in the same cycle.
REQ-010 ir  output  IR_W  instruction presented to the control unit.
REQ-011 run  output  1  high while an instruction is executing.
REQ-012 state  output  2  execution step counter driven to the control unit.
REQ-013 pc  output  ADDR_W  address of the current instruction.
REQ-014 busy  output  1  high in the FETCH and EXEC states.
REQ-015 halted  output  1  high in the HALT state.
REQ-016 error  output  1  sticky flag for a done timeout.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT.
REQ-018 IDLE: start=1 SHALL set pc to 0 and move to FETCH.
REQ-019 HALT: start=1 SHALL clear error, set pc to 0 and move to FETCH.
REQ-020 FETCH (1 cycle): ir SHALL be loaded with mem[pc].
  - opcode 111 (HALT): the FSM SHALL move to HALT with run=0 and pc unchanged.
  - any other opcode: the FSM SHALL move to EXEC with run=1 and state=0.
REQ-021 EXEC, done=1: state<=0, run<=0, pc<=pc+1 (modulo 2**ADDR_W, so 15 wraps to 0), next state FETCH.
REQ-022 EXEC, done=0 and state<3: state SHALL increment by 1.
REQ-023 EXEC, done=0 and state==3: error<=1, run<=0, state<=0, next state HALT; pc SHALL hold the faulting address.
REQ-024 Expected instruction lengths:
  - MV (000), MVI (001), MVO (100): 2 EXEC cycles.
  - ADD (010), SUB (011): 4 EXEC cycles.
  - Each instruction adds 1 FETCH cycle.
REQ-025 The sequencer SHALL not decode opcodes other than the HALT check; it SHALL issue opcodes 101 and 110 unchanged.
REQ-026 prog_we SHALL write mem[prog_addr] only in IDLE or HALT; writes SHALL be ignored while busy=1.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 done SHALL be ignored outside EXEC.
REQ-029 A write and a start in the same cycle (IDLE or HALT) SHALL both take effect, and the write SHALL commit before the FETCH read.
REQ-030 ir, run, state, pc and error SHALL be registered outputs.
REQ-031 busy and halted SHALL decode directly from the FSM state.

Reset
REQ-032 resetn_tb=0 at any time, including mid-EXEC, SHALL force IDLE with ir=0, run=0, state=0, pc=0, error=0, busy=0 and halted=0.
REQ-033 Program memory contents SHALL NOT be cleared by reset.
REQ-034 The first rising edge after resetn_tb deasserts SHALL act as normal IDLE behaviour.

Structure
REQ-035 A shared package cpu_pkg SHALL hold:
  - the opcode constants OP_MV=000, OP_MVI=001, OP_ADD=010, OP_SUB=011, OP_MVO=100, OP_HALT=111;
  - IR_W;
  - the sequencer FSM state enum.
REQ-036 The program memory SHALL be a sub-module prog_mem (2**ADDR_W x IR_W, synchronous write, asynchronous read) instantiated once.

Verification
REQ-037 Load {000_011_100, 010_001_010, 111_000_000}, pulse start, done modelled from the opcode -> run high for 2 cycles, then 4 cycles; halted after 9 cycles with pc=2.
REQ-038 Load 011_111_000 at address 0, start, done held low -> state steps 0,1,2,3; then error=1, halted=1, pc=0.
REQ-039 Mid-ADD at state=2, assert resetn_tb=0 -> all outputs 0 immediately; memory unchanged, verified by a re-run that matches REQ-037.
REQ-040 Fill all 16 words with 000_000_001 and start -> pc wraps from 15 to 0, busy stays 1, and no halt occurs within 60 cycles.
REQ-041 During EXEC, drive prog_we=1 to address 5 and pulse start -> mem[5] is unchanged and execution is unperturbed.
REQ-042 From HALT with error=1, pulse start -> error clears and FETCH occurs at pc=0 on the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, instruction width and sequencer state enum shared by the CPU blocks
package cpu_pkg;
  localparam int IR_W = 9;
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVO  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} seq_state_e;
endpackage

// File: rtl/prog_mem.sv
// prog_mem: program store with synchronous write and asynchronous read; contents survive reset
module prog_mem #(
  parameter int ADDR_W = 4,
  parameter int IR_W = 9
) (
  input  logic              clock_tb,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [IR_W-1:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [IR_W-1:0]   rdata
);
  logic [IR_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clock_tb)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches instructions from prog_mem and steps the control unit through each one
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int IR_W = cpu_pkg::IR_W
) (
  input  logic              clock_tb,
  input  logic              resetn_tb,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [IR_W-1:0]   prog_data,
  input  logic              done,
  output logic [IR_W-1:0]   ir,
  output logic              run,
  output logic [1:0]        state,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              error
);
  seq_state_e fsm, fsm_nxt;
  logic [IR_W-1:0] rdata;
  logic idle_or_halt, is_halt;
  assign idle_or_halt = fsm == S_IDLE || fsm == S_HALT;
  assign is_halt = rdata[IR_W-1 -: 3] == OP_HALT;
  prog_mem #(.ADDR_W(ADDR_W), .IR_W(IR_W)) u_mem (
    .clock_tb(clock_tb),
    .we(prog_we && idle_or_halt),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc),
    .rdata(rdata)
  );
  always_ff @(posedge clock_tb or negedge resetn_tb)
    if (!resetn_tb) fsm <= S_IDLE;
    else fsm <= fsm_nxt;
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      S_IDLE, S_HALT: fsm_nxt = start ? S_FETCH : fsm;
      S_FETCH:        fsm_nxt = is_halt ? S_HALT : S_EXEC;
      S_EXEC:         fsm_nxt = done ? S_FETCH : (state == 2'd3 ? S_HALT : S_EXEC);
      default:        fsm_nxt = S_IDLE;
    endcase
  end
  // done takes priority over the timeout on the last allowed step
  always_ff @(posedge clock_tb or negedge resetn_tb)
    if (!resetn_tb) begin
      ir <= '0;
      run <= 1'b0;
      state <= '0;
      pc <= '0;
      error <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: if (start) pc <= '0;
        S_HALT: if (start) begin
          pc <= '0;
          error <= 1'b0;
        end
        S_FETCH: begin
          ir <= rdata;
          run <= !is_halt;
          state <= '0;
        end
        S_EXEC: begin
          if (done) begin
            state <= '0;
            run <= 1'b0;
            pc <= pc + 1'b1;
          end else if (state != 2'd3) begin
            state <= state + 2'd1;
          end else begin
            error <= 1'b1;
            run <= 1'b0;
            state <= '0;
          end
        end
        default: ;
      endcase
    end
  assign busy = fsm == S_FETCH || fsm == S_EXEC;
  assign halted = fsm == S_HALT;
endmodule
